axi_wr_slave_ctrl: RTL

- Downstream consumer of the AXI write-path protocol FSM: the AXI slave-side write controller.
- Accepts one AW burst descriptor at a time and consumes its W beats.
- Computes the per-beat address for FIXED, INCR and WRAP bursts, drives a registered byte-strobed memory write port, and returns one B response per burst.
- Checks burst legality and WLAST consistency; errors are reported as SLVERR.

---
 rtl/axi_wr_slave_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_wr_slave_ctrl.sv
// AXI slave-side write controller: one AW burst at a time, per-beat address generation,
// registered byte-strobed memory write port and a single B response per burst.
module axi_wr_slave_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int MAXSIZE = 3
) (
  input  logic            axi_aclk,
  input  logic            axi_areset,
  input  logic [AW-1:0]   axi_awaddr,
  input  logic [7:0]      axi_awlen,
  input  logic [2:0]      axi_awsize,
  input  logic [1:0]      axi_awburst,
  input  logic            axi_awvalid,
  output logic            axi_awready,
  input  logic [DW-1:0]   axi_wdata,
  input  logic [DW/8-1:0] axi_wstrb,
  input  logic            axi_wlast,
  input  logic            axi_wvalid,
  output logic            axi_wready,
  output logic [1:0]      axi_bresp,
  output logic            axi_bvalid,
  input  logic            axi_bready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [15:0]     burst_cnt
);

  localparam logic [2:0] MAXSIZE_L = 3'(MAXSIZE);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [AW-1:0]   r_addr;
  logic [7:0]      r_len;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic [7:0]      r_beat;
  logic            r_err;

  logic            r_awready;
  logic            r_wready;
  logic            r_bvalid;
  logic [1:0]      r_bresp;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW/8-1:0] r_mem_wstrb;
  logic [15:0]     r_burst_cnt;

  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_b_hs;
  logic            w_last_beat;
  logic            w_wrap_len_ok;
  logic            w_aw_err;
  logic            w_err_nxt;

  logic            w_awready_nxt;
  logic            w_wready_nxt;
  logic            w_bvalid_nxt;
  logic [1:0]      w_bresp_nxt;
  logic            w_mem_we_nxt;

  logic [AW-1:0]   w_bytes;
  logic [AW-1:0]   w_span;
  logic [AW-1:0]   w_aligned;
  logic [AW-1:0]   w_wrap_base;
  logic [AW-1:0]   w_addr_nxt;

  assign w_aw_hs     = axi_awvalid & r_awready;
  assign w_w_hs      = axi_wvalid & r_wready;
  assign w_b_hs      = r_bvalid & axi_bready;
  assign w_last_beat = (r_beat == r_len);

  assign w_wrap_len_ok = (axi_awlen == 8'd1) | (axi_awlen == 8'd3) |
                         (axi_awlen == 8'd7) | (axi_awlen == 8'd15);
  assign w_aw_err = (axi_awsize > MAXSIZE_L) | (axi_awburst == 2'b11) |
                    ((axi_awburst == BURST_WRAP) & ~w_wrap_len_ok);

  // Beat address generation; INCR realigns after an unaligned first beat,
  // WRAP folds the incremented offset back into the span-aligned window.
  assign w_bytes     = {{(AW-1){1'b0}}, 1'b1} << r_size;
  assign w_span      = ({{(AW-8){1'b0}}, r_len} + {{(AW-1){1'b0}}, 1'b1}) << r_size;
  assign w_aligned   = r_addr & ~(w_bytes - {{(AW-1){1'b0}}, 1'b1});
  assign w_wrap_base = r_addr & ~(w_span - {{(AW-1){1'b0}}, 1'b1});

  always_comb begin
    w_addr_nxt = r_addr;
    case (r_burst)
      BURST_FIXED: w_addr_nxt = r_addr;
      BURST_INCR:  w_addr_nxt = w_aligned + w_bytes;
      BURST_WRAP:  w_addr_nxt = w_wrap_base |
                                ((r_addr + w_bytes) & (w_span - {{(AW-1){1'b0}}, 1'b1}));
      default:     w_addr_nxt = r_addr;
    endcase
  end

  // State register
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and error tracking
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_aw_hs) begin
          w_state_nxt = S_DATA;
          w_err_nxt   = w_aw_err;
        end
      end
      S_DATA: begin
        if (w_w_hs) begin
          if (axi_wlast && !w_last_beat) begin
            w_state_nxt = S_RESP;
            w_err_nxt   = 1'b1;
          end else if (w_last_beat && axi_wlast) begin
            w_state_nxt = S_RESP;
          end else if (w_last_beat) begin
            w_state_nxt = S_DRAIN;
            w_err_nxt   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_w_hs && axi_wlast) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (w_b_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so derive their next values from the next state
  always_comb begin
    w_awready_nxt = (w_state_nxt == S_IDLE);
    w_wready_nxt  = (w_state_nxt == S_DATA) | (w_state_nxt == S_DRAIN);
    w_bvalid_nxt  = (w_state_nxt == S_RESP);
    w_bresp_nxt   = RESP_OKAY;
    if ((w_state_nxt == S_RESP) && w_err_nxt) begin
      w_bresp_nxt = RESP_SLVERR;
    end
    w_mem_we_nxt  = (r_state == S_DATA) & w_w_hs & ~r_err;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_awready   <= 1'b1;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_err       <= 1'b0;
      r_burst_cnt <= 16'd0;
    end else begin
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      r_err     <= w_err_nxt;
      if (w_b_hs) begin
        r_burst_cnt <= r_burst_cnt + 16'd1;
      end
    end
  end

  // Burst descriptor and beat tracking
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_addr  <= '0;
      r_len   <= 8'd0;
      r_size  <= 3'd0;
      r_burst <= 2'b00;
      r_beat  <= 8'd0;
    end else if (w_aw_hs) begin
      r_addr  <= axi_awaddr;
      r_len   <= axi_awlen;
      r_size  <= axi_awsize;
      r_burst <= axi_awburst;
      r_beat  <= 8'd0;
    end else if (w_w_hs && (r_state == S_DATA)) begin
      r_addr  <= w_addr_nxt;
      r_beat  <= r_beat + 8'd1;
    end
  end

  // Memory write port, one cycle behind the W handshake
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_mem_we <= w_mem_we_nxt;
      if (w_mem_we_nxt) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= axi_wdata;
        r_mem_wstrb <= axi_wstrb;
      end
    end
  end

  assign axi_awready = r_awready;
  assign axi_wready  = r_wready;
  assign axi_bvalid  = r_bvalid;
  assign axi_bresp   = r_bresp;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wstrb   = r_mem_wstrb;
  assign burst_cnt   = r_burst_cnt;

endmodule
